// File: rtl/mcu32x_isa_pkg.sv
// Shared RV32 ISA definitions: opcode constants, NOP word, field positions
// and a small immediate range helper. The decode stage imports this package too.
package mcu32x_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  // Least-significant bit position of each fixed instruction field.
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_R,
    FMT_BAD
  } fmt_e;

  // True when imm[31:msb] are all copies of the sign bit, i.e. the value
  // survives truncation to a (msb+1)-bit signed field.
  function automatic logic imm_fits(input logic [31:0] imm, input int msb);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b >= msb && imm[b] != imm[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Small synchronous FIFO with registered storage, pointers and occupancy count.
// Read data is the head entry; a push into a full FIFO is ignored.
module instr_fifo2 #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Push is blocked whenever full, even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and count; reset clears everything, discarding queued words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields back into RV32 instruction words with range checks,
// queues them in a small output FIFO, and counts accepted bundles.
// Optional build macro: INSTR_ENCODER_RTYPE_EN adds R-type (opcode 0110011).
module instr_encoder
  import mcu32x_isa_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        immediate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_err,
  output logic               err_sticky,
  input  logic               clr_err,
  output logic [COUNT_W-1:0] instr_count
);

  fmt_e                   fmt;
  logic [31:0]            word;
  logic                   err;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [32:0]            fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   err_sticky_q, err_sticky_d;
  logic [COUNT_W-1:0]     count_q, count_d;

`ifndef INSTR_ENCODER_RTYPE_EN
  // funct7 only feeds R-type encoding, which this build does not support.
  logic unused_funct7;
  assign unused_funct7 = ^funct7;
`endif

  // Classify the opcode, then build the word and flag range/alignment errors.
  always_comb begin
    fmt  = FMT_BAD;
    word = INSTR_NOP;
    err  = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_OPIMM: fmt = FMT_I;
      OPC_STORE:           fmt = FMT_S;
      OPC_BRANCH:          fmt = FMT_B;
`ifdef INSTR_ENCODER_RTYPE_EN
      OPC_OP:              fmt = FMT_R;
`endif
      default:             fmt = FMT_BAD;
    endcase
    case (fmt)
      FMT_I: begin
        err  = !imm_fits(immediate, 11);
        word = {immediate[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        err  = !imm_fits(immediate, 11);
        word = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
      end
      FMT_B: begin
        err  = !imm_fits(immediate, 12) || immediate[0];
        word = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                immediate[4:1], immediate[11], opcode};
      end
`ifdef INSTR_ENCODER_RTYPE_EN
      FMT_R: begin
        err  = 1'b0;
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
`endif
      default: begin
        err  = 1'b1;
        word = INSTR_NOP;
      end
    endcase
    if (err) word = INSTR_NOP;
  end

  // in_ready depends only on registered FIFO state, never on out_ready.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_instr = fifo_rdata[31:0];
  assign out_err   = fifo_rdata[32];

  instr_fifo2 #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({err, word}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky error: an erroring push wins over a same-cycle clear; count wraps silently.
  always_comb begin
    err_sticky_d = err_sticky_q;
    count_d      = count_q;
    if (push && err)  err_sticky_d = 1'b1;
    else if (clr_err) err_sticky_d = 1'b0;
    if (push) count_d = count_q + COUNT_W'(1);
  end

  // Status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
      count_q      <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      count_q      <= count_d;
    end
  end

  assign err_sticky  = err_sticky_q;
  assign instr_count = count_q;

  // fifo_count is kept for visibility in simulation; fold it into a sink.
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline decode stage: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) into 32-bit RV32 instruction words.
- Used by the boot/self-test loader and the debug instruction-injection path to build words for instruction memory.
- Valid/ready on both sides, with a small registered output FIFO.
- Checks immediate range and alignment, and flags opcodes it cannot encode.

Parameters:
- DEPTH, 2, output FIFO entries; power of 2, >= 2.
- COUNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- opcode  in  7  instruction[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  function field
- funct7  in  7  function field (R-type only)
- immediate  in  32  sign-extended, unshifted immediate, as the decoder produces it
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded instruction word
- out_err  out  1  this word was substituted because of an error
- err_sticky  out  1  OR of every out_err pushed since reset or clear
- clr_err  in  1  synchronous clear of err_sticky
- instr_count  out  COUNT_W  number of bundles accepted

Behaviour:
- Reset (asynchronous, active-high, immediate effect even mid-transfer):
  - FIFO emptied; pointers and count go to 0.
  - in_ready=1, out_valid=0, out_instr=0, out_err=0, err_sticky=0, instr_count=0.
  - Words in flight are discarded.
- Accept: a bundle is taken when in_valid && in_ready on a rising clk edge.
  - The word is encoded combinationally and written into the FIFO.
  - Latency: accepted at edge N, visible at edge N+1 with out_valid=1 if the FIFO was empty.
- Handshakes:
  - in_ready = (fifo_count != DEPTH), taken from registered state only; no combinational path from out_ready.
  - When the FIFO is full, a pop in the same cycle does not allow a push.
  - Pop happens when out_valid && out_ready.
  - out_instr and out_err hold steady while out_valid && !out_ready.
  - Push and pop in the same cycle (not full, not empty): count unchanged, order preserved.
- Encoding:
  - Opcode 0000011 (load) and 0010011 (op-imm), I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - Opcode 0100011 (store), S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Opcode 1100011 (branch), B-type: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Unused fields are ignored.
- Error checks:
  - I/S: error unless immediate[31:11] are all equal.
  - B: error unless immediate[31:12] are all equal and immediate[0]==0.
  - Any other opcode is unsupported and raises an error.
  - On error the word is NOP 32'h00000013 with out_err=1. It is still accepted and counted.
- err_sticky:
  - Set on any push with an error.
  - clr_err clears it on the next edge.
  - clr_err in the same cycle as an error push: set wins.
- instr_count:
  - Increments by 1 per accepted bundle.
  - Wraps from 2^COUNT_W-1 to 0 with no flag.

Optional Feature:
- Macro: INSTR_ENCODER_RTYPE_EN.
- Defined: opcode 0110011 is encoded as R-type {funct7, rs2, rs1, funct3, rd, opcode} with no error.
- Not defined: 0110011 is unsupported and produces NOP with out_err=1.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mcu32x_isa_pkg:
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP.
  - INSTR_NOP = 32'h00000013.
  - Field-position localparams.
  - The decode stage uses the same package.
- One sub-module, instr_fifo2: a parameterised DEPTH synchronous FIFO with registered count, full and empty outputs.
- Encoding and range checking stay combinational inside instr_encoder.

Test Plan:
- lw x5,8(x2): opcode=0000011, rd=5, rs1=2, funct3=010, imm=8 -> out_instr=32'h00812283, out_err=0, one cycle after accept.
- sw x6,12(x2): opcode=0100011, rs1=2, rs2=6, funct3=010, imm=12 -> 32'h00612623.
- beq x1,x2,-8: opcode=1100011, rs1=1, rs2=2, funct3=000, imm=32'hFFFFFFF8 -> 32'hFE208CE3.
- Error cases -> each gives 32'h00000013 with out_err=1 and err_sticky=1; clr_err then clears the sticky flag:
  - addi with imm=2048.
  - beq with imm=3.
  - Opcode 0110111.
- Backpressure: out_ready=0, three bundles offered back to back (DEPTH=2) -> the first two are accepted, in_ready=0 on the third. Then out_ready=1 -> words emerge in order, the third is accepted only after count<2, and instr_count=3.
- Reset with 2 words queued -> out_valid drops immediately, in_ready=1, instr_count=0. The first new bundle after reset emerges correctly.
